// File: rtl/mul_iter_if.sv
// ============================================================================
// mul_iter_if : start/done handshake bundle for the iterative multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

interface mul_iter_if #(
  parameter int MSB = 31
);
  logic           start;
  logic [1:0]     op;
  logic [MSB:0]   in_a;
  logic [MSB:0]   in_b;
  logic [MSB:0]   out_low;
  logic [MSB:0]   out_high;
  logic           done;

  modport master (
    output start, op, in_a, in_b,
    input  out_low, out_high, done
  );

  modport slave (
    input  start, op, in_a, in_b,
    output out_low, out_high, done
  );
endinterface

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// mul_iter : iterative shift-and-add multiplier (MUL/MULH/MULHSU/MULHU)
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_iter #(
  parameter int MSB = 31
) (
  input  logic       clk,
  input  logic       rst,
  mul_iter_if.slave  bus
);
  localparam int W  = MSB + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a_mag;
  logic [W-1:0]    r_b;
  logic [2*W:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic [W-1:0]    r_low;
  logic [W-1:0]    r_high;

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [W:0]      w_sum;
  logic [2*W:0]    w_acc_next;
  logic [2*W-1:0]  w_mag;
  logic [2*W-1:0]  w_prod;

  assign w_a_signed = (bus.op == 2'b01) || (bus.op == 2'b10);
  assign w_b_signed = (bus.op == 2'b01);
  assign w_a_neg    = w_a_signed & bus.in_a[MSB];
  assign w_b_neg    = w_b_signed & bus.in_b[MSB];
  // Negating the most-negative value yields 2^(W-1), which is correct read as unsigned.
  assign w_a_mag    = w_a_neg ? -bus.in_a : bus.in_a;
  assign w_b_mag    = w_b_neg ? -bus.in_b : bus.in_b;

  // Upper W+1 bits absorb the add carry; the shift then drops the consumed LSB.
  assign w_sum      = r_acc[2*W:W] + (r_b[0] ? {1'b0, r_a_mag} : {(W+1){1'b0}});
  assign w_acc_next = {1'b0, w_sum, r_acc[W-1:1]};

  assign w_mag      = r_acc[2*W-1:0];
  assign w_prod     = r_neg ? -w_mag : w_mag;

  assign bus.done     = (r_state == S_IDLE);
  assign bus.out_low  = r_low;
  assign bus.out_high = r_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_mag <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_low   <= '0;
      r_high  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_mag <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(MSB)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_low   <= w_prod[W-1:0];
          r_high  <= w_prod[2*W-1:W];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
// ============================================================================
// tb_mul_iter : directed stimulus with queued expectations and result monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_iter;
  logic clk;
  logic rst;

  mul_iter_if #(.MSB(31)) bus ();

  mul_iter #(.MSB(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;   // expected done-low cycles, -1 = aborted op
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Result monitor: pops an expectation on every done rising edge.
  logic prev_done = 1'b1;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!bus.done) begin
      busy_cnt++;
    end else if (!prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got hi=0x%08h lo=0x%08h expected none",
                 bus.out_high, bus.out_low);
      end else begin
        e = exp_q.pop_front();
        check32({e.name, "_hi"}, bus.out_high, e.hi);
        check32({e.name, "_lo"}, bus.out_low, e.lo);
        if (e.busy >= 0) check32({e.name, "_busy"}, busy_cnt, e.busy);
      end
      busy_cnt = 0;
    end
    prev_done = bus.done;
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1", name);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi; e.lo = lo; e.busy = 33; e.name = name;
    exp_q.push_back(e);
    bus.op = op; bus.in_a = a; bus.in_b = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   rises;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.in_a = 32'hFFFF_FFFF;
    bus.in_b = 32'hFFFF_FFFF;

    // Reset held with start high: no launch.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check32("rst_done", {31'd0, bus.done}, 32'd1);
      check32("rst_hi", bus.out_high, 32'd0);
      check32("rst_lo", bus.out_low, 32'd0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check32("post_rst_idle", {31'd0, bus.done}, 32'd1);

    run_op("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mulh_m3x5", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mul_zero", 2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
    run_op("mul_unsigned", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_op("mulh_maxmin", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000);

    // Start pulse while busy must be ignored.
    e.hi = 32'd0; e.lo = 32'd42; e.busy = 33; e.name = "busy_start";
    exp_q.push_back(e);
    bus.op = 2'b11; bus.in_a = 32'd7; bus.in_b = 32'd6; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.in_a = 32'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start");
    repeat (3) begin
      @(negedge clk);
      check32("no_queued_launch", {31'd0, bus.done}, 32'd1);
    end

    // Start held high: three ops, one idle cycle between each.
    for (int i = 0; i < 3; i++) begin
      e.hi = 32'd0; e.lo = 32'd35; e.busy = 33; e.name = "b2b";
      exp_q.push_back(e);
    end
    bus.op = 2'b11; bus.in_a = 32'd5; bus.in_b = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    rises = 0;
    for (int n = 0; n < 200 && rises < 3; n++) begin
      @(negedge clk);
      if (bus.done) begin
        rises++;
        if (rises == 3) begin
          bus.start = 1'b0;
        end else begin
          @(negedge clk);
          check32("b2b_gap", {31'd0, bus.done}, 32'd0);
        end
      end
    end
    check32("b2b_count", rises, 32'd3);
    bus.start = 1'b0;
    @(negedge clk);

    // Reset mid-operation aborts and clears outputs.
    e.hi = 32'd0; e.lo = 32'd0; e.busy = -1; e.name = "abort";
    exp_q.push_back(e);
    bus.op = 2'b11; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("abort_done", {31'd0, bus.done}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_abort", 2'b11, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) @(negedge clk);
    check32("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mul_iter.md
# mul_iter

Iterative shift-and-add multiplier: takes two MSB+1-bit operands and returns the full 2×(MSB+1)-bit product over a fixed number of cycles. It supports the four signedness combinations needed by the M-extension MUL/MULH/MULHSU/MULHU instructions. It sits beside the iterative divider in the execute stage and uses the same start/done handshake, so the core's stall logic treats both units identically.

## Interface
- MSB, default 31: operand MSB index; W = MSB+1 is the operand width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  signedness: 00 MUL (unsigned×unsigned, low word used), 01 MULH signed×signed, 10 MULHSU signed a × unsigned b, 11 MULHU unsigned×unsigned.
- in_a  in  W  multiplicand, sampled with start.
- in_b  in  W  multiplier, sampled with start.
- out_low  out  W  product bits [W-1:0].
- out_high  out  W  product bits [2W-1:W].
- done  out  1  high when idle and results valid; low while busy.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: done=1. The block holds out_low/out_high. On start=1, it captures the operand magnitudes and the result sign, clears the accumulator and count, and goes to RUN. On start=0, it stays in IDLE.
- Magnitude: an operand treated as signed (in_a for op 01/10, in_b for op 01) with MSB=1 is two's-complement negated. Otherwise it is taken as-is. Result sign = XOR of the signed operands' MSBs; unsigned operands contribute 0.
- RUN: one multiplier bit per cycle, LSB first. If the current bit is 1, add the multiplicand magnitude into the upper W+1 bits of a 2W+1-bit accumulator. Then shift the accumulator right by 1. Count increments 0..MSB. After the cycle with count==MSB, go to FIX.
- FIX: if the result sign is 1, the final product is the two's-complement negation of the 2W-bit magnitude. Otherwise it is the magnitude unchanged. Write it to out_high:out_low and go to IDLE. FIX is always taken, so latency is fixed.
- Width rules: magnitudes are at most 2^(W-1) for signed operands and 2^W-1 for unsigned ones, so the unsigned 2W-bit product never overflows. The carry out of each add is kept in accumulator bit 2W. The most-negative operand, negated, is treated as an unsigned magnitude of 2^(W-1).
- Outputs change only on the FIX→IDLE edge or on reset. They are not updated during RUN.
- op, in_a and in_b are ignored outside the start-sampling cycle.

## Timing
- Reset: state=IDLE, done=1, out_low=0, out_high=0, accumulator/count/sign cleared.
- With start=1 sampled at edge k: RUN from k+1 through k+W, FIX at k+W+1, IDLE at k+W+2.
- done is low for exactly W+1 cycles (33 for W=32). out_low/out_high hold the new product from the cycle in which done returns high.
- done is decoded combinationally from state. It deasserts the cycle after start is sampled.
- start asserted in RUN or FIX is ignored and not queued.
- start held high continuously launches a new operation on each IDLE cycle. IDLE lasts 1 cycle between back-to-back ops.
- rst during RUN/FIX aborts the operation: next cycle is IDLE, done=1, outputs=0.
- rst and start in the same cycle: reset wins.

## Test plan
- Reset: assert rst 2 cycles with start=1 -> done=1, out_high=0, out_low=0. No launch occurs.
- MULHU, in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> done low exactly 33 cycles, then out_high=0xFFFFFFFE, out_low=0x00000001.
- MULH, in_a=0xFFFFFFFD (-3), in_b=0x00000005 -> out_high=0xFFFFFFFF, out_low=0xFFFFFFF1. Next op: MULH, in_a=0x80000000, in_b=0x80000000 -> out_high=0x40000000, out_low=0x00000000.
- MULHSU, in_a=0xFFFFFFFF (-1), in_b=0xFFFFFFFF (unsigned) -> out_high=0xFFFFFFFF, out_low=0x00000001. MUL, in_a=0, in_b=0x12345678 -> out_high=0, out_low=0.
- Busy-start: launch MULHU 7×6, pulse start with in_a=9 at RUN cycle 10 -> ignored; result out_low=42, out_high=0 after 33 busy cycles. start held high: back-to-back results separated by 1 done-high cycle.
- Reset mid-op: launch MULHU 0xFFFFFFFF×2, assert rst at RUN cycle 15 -> next cycle done=1, out_low=0, out_high=0. A new launch of 3×4 completes with out_low=12.
